uart_tx_ctrl: RTL and testbench

//  Frame controller for the UART transmitter. Sits directly downstream of the byte source and drives the serializer.

---
 rtl/uart_tx_ctrl.sv | 130 +++++++++++++
 tb/tb_uart_tx_ctrl.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_ctrl.sv
// uart_tx_ctrl: UART transmit frame sequencer.
//   Accepts a parallel byte request, walks START -> DATA -> [PARITY] -> STOP and
//   drives the line bit, the serializer enable and host status pulses.
// Ports:
//   clk, rst        clock and synchronous active-low reset
//   P_DATA          parallel byte, sampled on frame acceptance (parity only)
//   Data_Valid      send request (honoured in IDLE and on the last STOP cycle)
//   PAR_EN/PAR_TYP  parity enable / type (0 even, 1 odd), sampled on acceptance
//   Ser_data        serial data bit from the serializer
//   Ser_done        serializer's last data bit is on Ser_data
//   Ser_en          serializer enable (DATA only)
//   busy            state is not IDLE
//   TX_OUT          UART line, idles high
//   Tx_done         pulse on the last STOP cycle
//   Tx_err          pulse when DATA ends on count without Ser_done
//
// state  | meaning
// IDLE   | line high, waiting for Data_Valid
// START  | one start bit (line low)
// DATA   | serializer enabled, line follows Ser_data
// PARITY | one latched parity bit
// STOP   | STOP_BITS high cycles, may chain straight into START
module uart_tx_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int STOP_BITS  = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] P_DATA,
  input  logic                  Data_Valid,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  input  logic                  Ser_data,
  input  logic                  Ser_done,
  output logic                  Ser_en,
  output logic                  busy,
  output logic                  TX_OUT,
  output logic                  Tx_done,
  output logic                  Tx_err
);

  localparam int CW = $clog2(DATA_WIDTH) + 1;
  localparam logic [CW-1:0] BIT_LAST  = CW'(DATA_WIDTH - 1);
  localparam logic [1:0]    STOP_LAST = 2'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  state_t        state;
  logic [CW-1:0] bit_cnt;
  logic [1:0]    stop_cnt;
  logic          par_bit;
  logic          par_en_q;

  logic bit_last;
  logic stop_last;

  assign bit_last  = (bit_cnt == BIT_LAST);
  assign stop_last = (state == STOP) && (stop_cnt == STOP_LAST);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= IDLE;
      bit_cnt  <= '0;
      stop_cnt <= '0;
      par_bit  <= 1'b0;
      par_en_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (Data_Valid) begin
            state    <= START;
            par_en_q <= PAR_EN;
            par_bit  <= (^P_DATA) ^ PAR_TYP;
          end
        end
        START: begin
          state   <= DATA;
          bit_cnt <= '0;
        end
        DATA: begin
          // bit_cnt tops out at DATA_WIDTH, which fits in CW bits, so no wrap
          bit_cnt <= bit_cnt + 1'b1;
          if (Ser_done || bit_last) begin
            state    <= par_en_q ? PARITY : STOP;
            stop_cnt <= '0;
          end
        end
        PARITY: begin
          state    <= STOP;
          stop_cnt <= '0;
        end
        STOP: begin
          if (stop_cnt == STOP_LAST) begin
            if (Data_Valid) begin
              // back-to-back frame: no idle cycle between STOP and START
              state    <= START;
              par_en_q <= PAR_EN;
              par_bit  <= (^P_DATA) ^ PAR_TYP;
            end else begin
              state <= IDLE;
            end
          end else begin
            stop_cnt <= stop_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    Ser_en  = (state == DATA);
    busy    = (state != IDLE);
    Tx_done = stop_last;
    Tx_err  = (state == DATA) && bit_last && !Ser_done;
    case (state)
      START:   TX_OUT = 1'b0;
      DATA:    TX_OUT = Ser_data;
      PARITY:  TX_OUT = par_bit;
      default: TX_OUT = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_uart_tx_ctrl.sv
module tb_uart_tx_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst = 1'b0;
  logic       dv = 1'b0, pen = 1'b0, ptyp = 1'b0, sd = 1'b0, sdone = 1'b0;
  logic [7:0] pd = 8'h00;
  logic       ser_en, busy, tx, done, err;

  logic       dv2 = 1'b0, sd2 = 1'b0, sdone2 = 1'b0;
  logic [7:0] pd2 = 8'h5A;
  logic       ser_en2, busy2, tx2, done2, err2;

  uart_tx_ctrl #(.DATA_WIDTH(8), .STOP_BITS(1)) dut (
    .clk(clk), .rst(rst), .P_DATA(pd), .Data_Valid(dv), .PAR_EN(pen), .PAR_TYP(ptyp),
    .Ser_data(sd), .Ser_done(sdone), .Ser_en(ser_en), .busy(busy), .TX_OUT(tx),
    .Tx_done(done), .Tx_err(err));

  uart_tx_ctrl #(.DATA_WIDTH(8), .STOP_BITS(2)) dut2 (
    .clk(clk), .rst(rst), .P_DATA(pd2), .Data_Valid(dv2), .PAR_EN(1'b0), .PAR_TYP(1'b0),
    .Ser_data(sd2), .Ser_done(sdone2), .Ser_en(ser_en2), .busy(busy2), .TX_OUT(tx2),
    .Tx_done(done2), .Tx_err(err2));

  int total = 0;
  int bad   = 0;

  task automatic chk(string name, logic act, logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0b expected %0b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chki(string name, int act, int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: each accepted frame expands into a list of per-cycle
  // records (what the bench serializer drives and what the line must show).
  typedef struct {
    logic sd, sdone, tx, en, busy, done, err, last;
  } rec_t;
  rec_t q[$];

  function automatic rec_t idle_rec();
    rec_t r;
    r.sd = 1'($urandom); r.sdone = 1'($urandom);
    r.tx = 1'b1; r.en = 1'b0; r.busy = 1'b0; r.done = 1'b0; r.err = 1'b0; r.last = 1'b1;
    return r;
  endfunction

  function automatic void build(logic [7:0] p, logic pe, logic pt, int done_at, logic [7:0] bits);
    rec_t r;
    int   n;
    n = (done_at >= 1 && done_at <= 8) ? done_at : 8;
    r.sd = 1'($urandom); r.sdone = 1'($urandom);
    r.tx = 1'b0; r.en = 1'b0; r.busy = 1'b1; r.done = 1'b0; r.err = 1'b0; r.last = 1'b0;
    q.push_back(r);
    for (int i = 0; i < n; i++) begin
      r.sd = bits[i]; r.sdone = (i + 1 == done_at); r.tx = bits[i]; r.en = 1'b1;
      r.err = (i == 7) && (done_at != 8);
      q.push_back(r);
    end
    r.en = 1'b0; r.err = 1'b0;
    if (pe) begin
      r.sd = 1'($urandom); r.sdone = 1'($urandom); r.tx = (^p) ^ pt;
      q.push_back(r);
    end
    r.sd = 1'($urandom); r.sdone = 1'($urandom);
    r.tx = 1'b1; r.done = 1'b1; r.last = 1'b1;
    q.push_back(r);
  endfunction

  task automatic cyc(logic r_n, logic v, logic [7:0] p, logic pe, logic pt, int done_at);
    rec_t       cur;
    logic [7:0] bits;
    @(negedge clk);
    if (q.size() > 0) cur = q.pop_front();
    else cur = idle_rec();
    rst = r_n; dv = v; pd = p; pen = pe; ptyp = pt; sd = cur.sd; sdone = cur.sdone;
    #2;
    chk("tx_out", tx, cur.tx);
    chk("ser_en", ser_en, cur.en);
    chk("busy", busy, cur.busy);
    chk("tx_done", done, cur.done);
    chk("tx_err", err, cur.err);
    if (!r_n) q.delete();
    else if (cur.last && v) begin
      bits = 8'($urandom);
      build(p, pe, pt, done_at, bits);
    end
  endtask

  task automatic drain();
    repeat (15) cyc(1'b1, 1'b0, 8'($urandom), 1'b0, 1'b0, 8);
  endtask

  // Directed frame vectors with hand-derived expectations.
  typedef struct {
    logic [7:0] p;
    logic       pe, pt;
    int         done_at, len, par, errs;
  } vec_t;
  vec_t vt[8];

  task automatic run_vec(vec_t v);
    int   len, done_pos, errs, en_cnt;
    logic tr[0:40];
    len = 0; done_pos = 0; errs = 0; en_cnt = 0;
    for (int i = 0; i <= 40; i++) tr[i] = 1'bx;
    @(negedge clk);
    rst = 1'b1; dv = 1'b1; pd = v.p; pen = v.pe; ptyp = v.pt; sdone = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      dv = 1'b0; pd = 8'($urandom); pen = 1'($urandom); ptyp = 1'($urandom);
      if (ser_en) begin
        en_cnt++;
        sd = 1'($urandom);
        sdone = (en_cnt == v.done_at);
      end else begin
        sd = 1'b0; sdone = 1'b0;
      end
      #2;
      if (!busy) break;
      len++;
      tr[len] = tx;
      if (ser_en) chk("vec_data_bit", tx, sd);
      if (done) done_pos = len;
      if (err) errs++;
    end
    chki("vec_len", len, v.len);
    chki("vec_done_pos", done_pos, v.len);
    chki("vec_err_cnt", errs, v.errs);
    chk("vec_start_bit", tr[1], 1'b0);
    chk("vec_stop_bit", tr[v.len], 1'b1);
    if (v.pe) chk("vec_parity", tr[v.len - 1], v.par[0]);
  endtask

  task automatic run_stop2();
    int len, done_cnt, en_cnt;
    len = 0; done_cnt = 0; en_cnt = 0;
    @(negedge clk);
    dv2 = 1'b1;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      dv2 = 1'b0;
      if (ser_en2) begin
        en_cnt++;
        sd2 = 1'($urandom);
        sdone2 = (en_cnt == 8);
      end else begin
        sd2 = 1'b0; sdone2 = 1'b0;
      end
      #2;
      if (!busy2) break;
      len++;
      if (len >= 10) chk("stop2_line_high", tx2, 1'b1);
      chk("stop2_done_timing", done2, len == 11);
      chk("stop2_no_err", err2, 1'b0);
      if (done2) done_cnt++;
    end
    chki("stop2_len", len, 11);
    chki("stop2_done_cnt", done_cnt, 1);
  endtask

  initial begin
    vt[0] = '{8'hA5, 1'b1, 1'b0, 8, 11, 0, 0};
    vt[1] = '{8'hA5, 1'b1, 1'b1, 8, 11, 1, 0};
    vt[2] = '{8'hA5, 1'b0, 1'b0, 8, 10, 0, 0};
    vt[3] = '{8'hA5, 1'b1, 1'b0, 0, 11, 0, 1};
    vt[4] = '{8'hA5, 1'b1, 1'b0, 3,  6, 0, 0};
    vt[5] = '{8'hFF, 1'b1, 1'b0, 8, 11, 0, 0};
    vt[6] = '{8'h01, 1'b1, 1'b1, 8, 11, 0, 0};
    vt[7] = '{8'h07, 1'b1, 1'b0, 5,  8, 1, 0};

    // reset held with a pending request, then the frame starts on the first rst=1 edge
    rst = 1'b0; dv = 1'b1;
    repeat (3) cyc(1'b0, 1'b1, 8'hA5, 1'b1, 1'b0, 8);
    cyc(1'b1, 1'b1, 8'hA5, 1'b1, 1'b0, 8);
    drain();

    for (int i = 0; i < 8; i++) run_vec(vt[i]);
    drain();

    // back-to-back: request held high across the 3C frame's STOP cycle
    cyc(1'b1, 1'b1, 8'h3C, 1'b1, 1'b0, 8);
    repeat (11) cyc(1'b1, 1'b1, 8'hFF, 1'b1, 1'b0, 8);
    drain();

    // reset during DATA aborts; next request gives a clean frame
    cyc(1'b1, 1'b1, 8'h96, 1'b1, 1'b1, 8);
    repeat (3) cyc(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 8);
    cyc(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8);
    cyc(1'b1, 1'b1, 8'h96, 1'b1, 1'b1, 8);
    drain();

    run_stop2();

    for (int i = 0; i < 400; i++) begin
      cyc(($urandom_range(0, 79) != 0), ($urandom_range(0, 99) < 30), 8'($urandom),
          1'($urandom), 1'($urandom), int'($urandom_range(0, 9)));
    end
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
